// File: rtl/pipeline_run_controller.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_run_controller
// Brief   : Run/step/halt sequencer driving PC and stage-register enables and
//           flushes of a 5-stage MIPS pipeline for the debug path.
// Revision: 1.0 - initial release
// ============================================================================
module pipeline_run_controller #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cmd_valid,
  input  logic [1:0]       i_cmd,
  input  logic             i_halt_id,
  input  logic             i_load_use_hazard,
  input  logic             i_branch_taken,
  output logic             o_pc_en,
  output logic             o_ifid_en,
  output logic             o_ifid_flush,
  output logic             o_idex_flush,
  output logic             o_pipe_en,
  output logic             o_pc_clr,
  output logic             o_halted,
  output logic             o_busy,
  output logic [2:0]       o_state,
  output logic [CNT_W-1:0] o_cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_DRAIN  = 3'd3,
    S_HALTED = 3'd4,
    S_CLEAR  = 3'd5
  } state_e;

  localparam logic [1:0] C_STOP  = 2'b00;
  localparam logic [1:0] C_RUN   = 2'b01;
  localparam logic [1:0] C_STEP  = 2'b10;
  localparam logic [1:0] C_CLEAR = 2'b11;

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES - 1);

  state_e           state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      drain_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    drain_d      = drain_q;
    o_pc_en      = 1'b0;
    o_ifid_en    = 1'b0;
    o_ifid_flush = 1'b0;
    o_idex_flush = 1'b0;
    o_pipe_en    = 1'b0;
    o_pc_clr     = 1'b0;
    o_halted     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_cmd_valid) begin
          case (i_cmd)
            C_RUN:   state_d = S_RUN;
            C_STEP:  state_d = S_STEP;
            C_CLEAR: state_d = S_CLEAR;
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_RUN, S_STEP: begin
        o_pipe_en = 1'b1;
        // HALT outranks hazards, branches and a concurrent STOP
        if (i_halt_id) begin
          o_idex_flush = 1'b1;
          drain_d      = DRAIN_INIT;
          state_d      = (DRAIN_CYCLES == 1) ? S_HALTED : S_DRAIN;
        end else begin
          if (i_load_use_hazard) begin
            o_idex_flush = 1'b1;
          end else begin
            o_pc_en      = 1'b1;
            o_ifid_en    = 1'b1;
            o_ifid_flush = i_branch_taken;
          end
          if (state_q == S_STEP) begin
            state_d = S_IDLE;
          end else if (i_cmd_valid && (i_cmd == C_STOP)) begin
            state_d = S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        o_pipe_en    = 1'b1;
        o_idex_flush = 1'b1;
        // Counter value 1 marks the last drain cycle
        if (drain_q <= DW'(1)) begin
          drain_d = '0;
          state_d = S_HALTED;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      S_HALTED: begin
        o_halted = 1'b1;
        if (i_cmd_valid && (i_cmd == C_CLEAR)) begin
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        o_pc_clr     = 1'b1;
        o_ifid_flush = 1'b1;
        o_idex_flush = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_CLEAR) begin
      cnt_d = '0;
    end else if (o_pipe_en && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign o_busy        = (state_q == S_RUN) || (state_q == S_STEP) || (state_q == S_DRAIN);
  assign o_state       = state_q;
  assign o_cycle_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_run_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipeline_run_controller
// Brief   : Directed self-checking bench for pipeline_run_controller.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pipeline_run_controller;

  localparam int CNT_W = 32;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             i_cmd_valid = 1'b0;
  logic [1:0]       i_cmd = 2'b00;
  logic             i_halt_id = 1'b0;
  logic             i_load_use_hazard = 1'b0;
  logic             i_branch_taken = 1'b0;
  logic             o_pc_en, o_ifid_en, o_ifid_flush, o_idex_flush;
  logic             o_pipe_en, o_pc_clr, o_halted, o_busy;
  logic [2:0]       o_state;
  logic [CNT_W-1:0] o_cycle_count;

  int checks = 0;
  int errors = 0;

  // {pc_en, ifid_en, ifid_flush, idex_flush, pipe_en, pc_clr, halted, busy, state}
  logic [10:0] outs;
  assign outs = {o_pc_en, o_ifid_en, o_ifid_flush, o_idex_flush, o_pipe_en,
                 o_pc_clr, o_halted, o_busy, o_state};

  localparam logic [10:0] O_IDLE  = {8'b0000_0000, 3'd0};
  localparam logic [10:0] O_RUN   = {8'b1100_1001, 3'd1};
  localparam logic [10:0] O_STALL = {8'b0001_1001, 3'd1};
  localparam logic [10:0] O_BR    = {8'b1110_1001, 3'd1};
  localparam logic [10:0] O_STEP  = {8'b1100_1001, 3'd2};
  localparam logic [10:0] O_DRAIN = {8'b0001_1001, 3'd3};
  localparam logic [10:0] O_HALT  = {8'b0000_0010, 3'd4};
  localparam logic [10:0] O_CLR   = {8'b0011_0100, 3'd5};
  localparam logic [10:0] O_ZERO  = 11'd0;

  localparam logic [1:0] C_STOP  = 2'b00;
  localparam logic [1:0] C_RUN   = 2'b01;
  localparam logic [1:0] C_STEP  = 2'b10;
  localparam logic [1:0] C_CLEAR = 2'b11;

  pipeline_run_controller #(.DRAIN_CYCLES(3), .CNT_W(CNT_W)) dut (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .i_cmd_valid       (i_cmd_valid),
    .i_cmd             (i_cmd),
    .i_halt_id         (i_halt_id),
    .i_load_use_hazard (i_load_use_hazard),
    .i_branch_taken    (i_branch_taken),
    .o_pc_en           (o_pc_en),
    .o_ifid_en         (o_ifid_en),
    .o_ifid_flush      (o_ifid_flush),
    .o_idex_flush      (o_idex_flush),
    .o_pipe_en         (o_pipe_en),
    .o_pc_clr          (o_pc_clr),
    .o_halted          (o_halted),
    .o_busy            (o_busy),
    .o_state           (o_state),
    .o_cycle_count     (o_cycle_count)
  );

  always #5 i_clk = ~i_clk;

  // Inputs change on the falling edge; outputs are sampled 1 ns later
  task automatic drive(input logic v, input logic [1:0] c, input logic h,
                       input logic hz, input logic br);
    @(negedge i_clk);
    i_cmd_valid       = v;
    i_cmd             = c;
    i_halt_id         = h;
    i_load_use_hazard = hz;
    i_branch_taken    = br;
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge i_clk);
    #1;
    checks++;
    if (outs !== O_ZERO || o_cycle_count !== '0) begin
      errors++;
      $display("FAIL reset_held outs=%b cnt=%0d expected outs=%b cnt=0", outs, o_cycle_count, O_ZERO);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    drive(1'b0, C_STOP, 1'b0, 1'b0, 1'b0);
    checks++;
    if (outs !== O_IDLE || o_cycle_count !== '0) begin
      errors++;
      $display("FAIL reset_idle outs=%b cnt=%0d expected outs=%b cnt=0", outs, o_cycle_count, O_IDLE);
    end
  endtask

  task automatic test_run();
    drive(1'b1, C_STOP, 1'b0, 1'b0, 1'b0);
    drive(1'b1, C_RUN, 1'b0, 1'b0, 1'b0);
    checks++;
    if (outs !== O_IDLE) begin
      errors++;
      $display("FAIL run_idle_before outs=%b expected %b", outs, O_IDLE);
    end
    for (int i = 0; i < 10; i++) begin
      drive(i == 9, C_STOP, 1'b0, 1'b0, 1'b0);
      checks++;
      if (outs !== O_RUN) begin
        errors++;
        $display("FAIL run_cycle%0d outs=%b expected %b", i, outs, O_RUN);
      end
    end
    drive(1'b0, C_STOP, 1'b0, 1'b0, 1'b0);
    checks++;
    if (outs !== O_IDLE || o_cycle_count !== 32'd10) begin
      errors++;
      $display("FAIL run_stop outs=%b cnt=%0d expected outs=%b cnt=10", outs, o_cycle_count, O_IDLE);
    end
  endtask

  task automatic test_clear_from_idle();
    drive(1'b1, C_CLEAR, 1'b0, 1'b0, 1'b0);
    drive(1'b0, C_STOP, 1'b0, 1'b0, 1'b0);
    checks++;
    if (outs !== O_CLR) begin
      errors++;
      $display("FAIL idle_clear outs=%b expected %b", outs, O_CLR);
    end
    drive(1'b0, C_STOP, 1'b0, 1'b0, 1'b0);
    checks++;
    if (outs !== O_IDLE || o_cycle_count !== '0) begin
      errors++;
      $display("FAIL idle_clear_after outs=%b cnt=%0d expected outs=%b cnt=0", outs, o_cycle_count, O_IDLE);
    end
  endtask

  task automatic test_step();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, C_STEP, 1'b0, 1'b0, 1'b0);
      checks++;
      if (outs !== O_IDLE) begin
        errors++;
        $display("FAIL step%0d_idle outs=%b expected %b", k, outs, O_IDLE);
      end
      // RUN offered during the step must be ignored
      drive(1'b1, C_RUN, 1'b0, 1'b0, 1'b0);
      checks++;
      if (outs !== O_STEP) begin
        errors++;
        $display("FAIL step%0d_pulse outs=%b expected %b", k, outs, O_STEP);
      end
    end
    drive(1'b0, C_STOP, 1'b0, 1'b0, 1'b0);
    checks++;
    if (outs !== O_IDLE || o_cycle_count !== 32'd3) begin
      errors++;
      $display("FAIL step_done outs=%b cnt=%0d expected outs=%b cnt=3", outs, o_cycle_count, O_IDLE);
    end
  endtask

  task automatic test_hazard();
    drive(1'b1, C_RUN, 1'b0, 1'b0, 1'b0);
    drive(1'b0, C_STOP, 1'b0, 1'b1, 1'b1);
    checks++;
    if (outs !== O_STALL) begin
      errors++;
      $display("FAIL hazard_stall outs=%b expected %b", outs, O_STALL);
    end
    drive(1'b0, C_STOP, 1'b0, 1'b0, 1'b1);
    checks++;
    if (outs !== O_BR) begin
      errors++;
      $display("FAIL hazard_branch outs=%b expected %b", outs, O_BR);
    end
    drive(1'b1, C_STOP, 1'b0, 1'b0, 1'b0);
    checks++;
    if (outs !== O_RUN) begin
      errors++;
      $display("FAIL hazard_stop_cycle outs=%b expected %b", outs, O_RUN);
    end
    drive(1'b0, C_STOP, 1'b0, 1'b0, 1'b0);
    checks++;
    if (outs !== O_IDLE || o_cycle_count !== 32'd6) begin
      errors++;
      $display("FAIL hazard_after outs=%b cnt=%0d expected outs=%b cnt=6", outs, o_cycle_count, O_IDLE);
    end
  endtask

  task automatic test_halt();
    drive(1'b1, C_RUN, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, C_STOP, 1'b0, 1'b0, 1'b0);
      checks++;
      if (outs !== O_RUN) begin
        errors++;
        $display("FAIL halt_run%0d outs=%b expected %b", i, outs, O_RUN);
      end
    end
    // STOP, hazard and branch alongside HALT: halt wins
    drive(1'b1, C_STOP, 1'b1, 1'b1, 1'b1);
    checks++;
    if (outs !== O_STALL) begin
      errors++;
      $display("FAIL halt_detect outs=%b expected %b", outs, O_STALL);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, C_RUN, 1'b0, 1'b0, 1'b1);
      checks++;
      if (outs !== O_DRAIN) begin
        errors++;
        $display("FAIL halt_drain%0d outs=%b expected %b", i, outs, O_DRAIN);
      end
    end
    drive(1'b1, C_RUN, 1'b0, 1'b0, 1'b0);
    checks++;
    if (outs !== O_HALT || o_cycle_count !== 32'd13) begin
      errors++;
      $display("FAIL halt_parked outs=%b cnt=%0d expected outs=%b cnt=13", outs, o_cycle_count, O_HALT);
    end
    drive(1'b1, C_STEP, 1'b0, 1'b0, 1'b0);
    checks++;
    if (outs !== O_HALT) begin
      errors++;
      $display("FAIL halt_run_dropped outs=%b expected %b", outs, O_HALT);
    end
    drive(1'b0, C_STOP, 1'b0, 1'b0, 1'b0);
    checks++;
    if (outs !== O_HALT || o_cycle_count !== 32'd13) begin
      errors++;
      $display("FAIL halt_step_dropped outs=%b cnt=%0d expected outs=%b cnt=13", outs, o_cycle_count, O_HALT);
    end
  endtask

  task automatic test_clear();
    drive(1'b1, C_CLEAR, 1'b0, 1'b0, 1'b0);
    drive(1'b0, C_STOP, 1'b0, 1'b0, 1'b0);
    checks++;
    if (outs !== O_CLR || o_cycle_count !== 32'd13) begin
      errors++;
      $display("FAIL clear_cycle outs=%b cnt=%0d expected outs=%b cnt=13", outs, o_cycle_count, O_CLR);
    end
    drive(1'b1, C_RUN, 1'b0, 1'b0, 1'b0);
    checks++;
    if (outs !== O_IDLE || o_cycle_count !== '0) begin
      errors++;
      $display("FAIL clear_idle outs=%b cnt=%0d expected outs=%b cnt=0", outs, o_cycle_count, O_IDLE);
    end
    drive(1'b0, C_STOP, 1'b0, 1'b0, 1'b0);
    checks++;
    if (outs !== O_RUN) begin
      errors++;
      $display("FAIL clear_run_accepted outs=%b expected %b", outs, O_RUN);
    end
  endtask

  task automatic test_reset_in_drain();
    drive(1'b0, C_STOP, 1'b1, 1'b0, 1'b0);
    drive(1'b0, C_STOP, 1'b0, 1'b0, 1'b0);
    drive(1'b0, C_STOP, 1'b0, 1'b0, 1'b0);
    checks++;
    if (outs !== O_DRAIN || o_cycle_count !== 32'd3) begin
      errors++;
      $display("FAIL drain_last outs=%b cnt=%0d expected outs=%b cnt=3", outs, o_cycle_count, O_DRAIN);
    end
    i_rst = 1'b1;
    #1;
    checks++;
    if (outs !== O_ZERO || o_cycle_count !== '0) begin
      errors++;
      $display("FAIL drain_reset_async outs=%b cnt=%0d expected outs=%b cnt=0", outs, o_cycle_count, O_ZERO);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    drive(1'b0, C_STOP, 1'b0, 1'b0, 1'b0);
    checks++;
    if (outs !== O_IDLE || o_cycle_count !== '0 || o_halted !== 1'b0) begin
      errors++;
      $display("FAIL drain_reset_release outs=%b cnt=%0d expected outs=%b cnt=0", outs, o_cycle_count, O_IDLE);
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_clear_from_idle();
    test_step();
    test_hazard();
    test_halt();
    test_clear();
    test_reset_in_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
